// File: rtl/kalman_update_sched_if.sv
// kalman_update_sched_if: ADC AXIS sample stream plus the start/done handshake
// to the shared Kalman arithmetic unit; master is the scheduler side.
interface kalman_update_sched_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IN_tdata;
    logic                        S_AXIS_IN_tvalid;
    logic                        S_AXIS_IN_tready;
    logic                        op_start;
    logic [2:0]                  op_code;
    logic                        op_done;

    modport master (
        input  S_AXIS_IN_tdata, S_AXIS_IN_tvalid, op_done,
        output S_AXIS_IN_tready, op_start, op_code
    );

    modport slave (
        output S_AXIS_IN_tdata, S_AXIS_IN_tvalid, op_done,
        input  S_AXIS_IN_tready, op_start, op_code
    );
endinterface

// File: rtl/kalman_update_sched.sv
// kalman_update_sched: captures one ADC sample per period and sequences the scalar
// Kalman ops through a shared arithmetic unit, reporting overruns and unit timeouts.
module kalman_update_sched #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ADC_WIDTH        = 14,
    parameter int PERIOD_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    kalman_update_sched_if.master   bus,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    init_req,
    output logic [ADC_WIDTH-1:0]    sample_out,
    output logic                    sample_load,
    output logic                    update_done,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [PERIOD_WIDTH-1:0] overrun_cnt
);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SAMPLE, S_ISSUE, S_WAIT_DONE, S_COMMIT} state_t;

    state_t                  r_state, w_next;
    logic [PERIOD_WIDTH-1:0] r_timer, r_ovr;
    logic [WW-1:0]           r_wait;
    logic [2:0]              r_op, w_op;
    logic [ADC_WIDTH-1:0]    r_sample;
    logic                    r_load, r_init_pend, r_timeout;
    logic                    w_active, w_tick, w_capture, w_expire, w_issue0, w_overrun;

    assign w_active  = enable && period != '0;
    assign w_tick    = w_active && r_timer == period - PERIOD_WIDTH'(1);
    assign w_issue0  = r_state == S_ISSUE && r_op == 3'd0;
    // a tick that cannot start an update (busy, or init about to take IDLE) is lost
    assign w_overrun = w_tick && (r_state != S_IDLE || r_init_pend);
    assign w_capture = r_state == S_WAIT_SAMPLE && bus.S_AXIS_IN_tvalid;
    assign w_expire  = r_state == S_WAIT_DONE && !bus.op_done && r_wait == WW'(TIMEOUT_CYCLES - 1);

    assign bus.S_AXIS_IN_tready = r_state == S_WAIT_SAMPLE;
    assign bus.op_start         = r_state == S_ISSUE;
    assign bus.op_code          = r_op;
    assign update_done          = r_state == S_COMMIT;
    assign busy                 = r_state != S_IDLE;
    assign sample_out           = r_sample;
    assign sample_load          = r_load;
    assign timeout_err          = r_timeout;
    assign overrun_cnt          = r_ovr;

    always_comb begin
        w_next = r_state;
        w_op   = r_op;
        case (r_state)
            S_IDLE: begin
                w_next = r_init_pend ? S_ISSUE : w_tick ? S_WAIT_SAMPLE : S_IDLE;
                w_op   = r_init_pend ? 3'd0 : r_op;
            end
            S_WAIT_SAMPLE: begin
                w_next = w_capture ? S_ISSUE : S_WAIT_SAMPLE;
                w_op   = w_capture ? 3'd1 : r_op;
            end
            S_ISSUE: w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.op_done) begin
                    w_next = r_op == 3'd0 ? S_IDLE : r_op >= 3'd5 ? S_COMMIT : S_ISSUE;
                    w_op   = (r_op == 3'd0 || r_op >= 3'd5) ? r_op : r_op + 3'd1;
                end else if (w_expire) begin
                    w_next = S_IDLE;
                end
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_timer     <= '0;
            r_wait      <= '0;
            r_ovr       <= '0;
            r_sample    <= '0;
            r_load      <= 1'b0;
            r_init_pend <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_op        <= w_op;
            r_timer     <= (!w_active || w_tick) ? '0 : r_timer + PERIOD_WIDTH'(1);
            r_wait      <= r_state == S_WAIT_DONE ? r_wait + WW'(1) : '0;
            r_init_pend <= init_req | (r_init_pend & ~w_issue0);
            r_timeout   <= w_expire | (r_timeout & ~w_issue0);
            r_load      <= w_capture;
            if (w_capture)
                r_sample <= bus.S_AXIS_IN_tdata[ADC_WIDTH-1:0];
            if (w_overrun && r_ovr != '1)
                r_ovr <= r_ovr + PERIOD_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_kalman_update_sched.sv
// tb_kalman_update_sched: randomized scenarios checked against a tick-level model of
// update timing (ticks, busy windows, dropped ticks) derived from the op sequence.
module tb_kalman_update_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        init_req = 1'b0;
    logic [15:0] period = 16'd0;
    logic [13:0] sample_out;
    logic        sample_load, update_done, busy, timeout_err;
    logic [15:0] overrun_cnt;

    int   n_cmp = 0, n_fail = 0, cyc = 0, lat = 1, cnt = 0;
    bit   resp_en = 1'b1, pend = 1'b0;
    int   done_q[$], opc_q[$], loadc_q[$];
    logic [2:0]  op_q[$];
    logic [13:0] load_q[$];

    kalman_update_sched_if #(.AXIS_TDATA_WIDTH(32)) bus ();

    kalman_update_sched #(
        .AXIS_TDATA_WIDTH(32), .ADC_WIDTH(14), .PERIOD_WIDTH(16), .TIMEOUT_CYCLES(256)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .enable(enable), .period(period),
        .init_req(init_req), .sample_out(sample_out), .sample_load(sample_load),
        .update_done(update_done), .busy(busy), .timeout_err(timeout_err),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // arithmetic unit model answering lat cycles after op_start, plus event recorder
    always @(negedge clk) begin
        bus.op_done = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (bus.op_start) begin
            op_q.push_back(bus.op_code);
            opc_q.push_back(cyc);
            pend = resp_en;
            cnt = lat;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                bus.op_done = 1'b1;
                pend = 1'b0;
            end
        end
        if (update_done) done_q.push_back(cyc);
        if (sample_load) begin
            load_q.push_back(sample_out);
            loadc_q.push_back(cyc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        done_q.delete(); opc_q.delete(); loadc_q.delete(); op_q.delete(); load_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.S_AXIS_IN_tvalid = 1'b0;
        bus.S_AXIS_IN_tdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.op_start, bus.op_code, bus.S_AXIS_IN_tready, busy} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.op_start, bus.op_code, bus.S_AXIS_IN_tready, busy});
        end
        n_cmp++;
        if ({sample_out, sample_load, update_done, timeout_err, overrun_cnt} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {sample_out, sample_load, update_done, timeout_err, overrun_cnt});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_periodic(input string nm, input int p, input int l, input int run);
        int c, d_end, free_at, n_ovr;
        int exp_done[$], exp_load[$];
        logic [31:0] d;
        logic [15:0] ovr0;
        d = $urandom;
        @(negedge clk);
        clear_q();
        lat = l; resp_en = 1'b1;
        bus.S_AXIS_IN_tdata = d; bus.S_AXIS_IN_tvalid = 1'b1;
        period = 16'(p);
        ovr0 = overrun_cnt;
        c = cyc;
        enable = 1'b1;
        repeat (run) @(negedge clk);
        enable = 1'b0;
        d_end = cyc;
        repeat (20 + 5 * l) @(negedge clk);
        free_at = 0; n_ovr = 0;
        for (int t = c + p - 1; t < d_end; t += p) begin
            if (t >= free_at) begin
                exp_load.push_back(t + 2);
                exp_done.push_back(t + 7 + 5 * l);
                free_at = t + 8 + 5 * l;
            end else begin
                n_ovr++;
            end
        end
        n_cmp++;
        if (done_q.size() != exp_done.size()) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d want %0d", nm, done_q.size(), exp_done.size());
        end
        for (int i = 0; i < done_q.size() && i < exp_done.size(); i++) begin
            n_cmp++;
            if (done_q[i] != exp_done[i]) begin
                n_fail++;
                $display("FAIL %s done_cycle[%0d]: got %0d want %0d", nm, i, done_q[i], exp_done[i]);
            end
        end
        n_cmp++;
        if (loadc_q.size() != exp_load.size()) begin
            n_fail++;
            $display("FAIL %s load_count: got %0d want %0d", nm, loadc_q.size(), exp_load.size());
        end
        for (int i = 0; i < loadc_q.size() && i < exp_load.size(); i++) begin
            n_cmp++;
            if (loadc_q[i] != exp_load[i] || load_q[i] !== d[13:0]) begin
                n_fail++;
                $display("FAIL %s load[%0d]: got cyc %0d val %h want cyc %0d val %h", nm, i, loadc_q[i], load_q[i], exp_load[i], d[13:0]);
            end
        end
        n_cmp++;
        if (op_q.size() != 5 * exp_done.size()) begin
            n_fail++;
            $display("FAIL %s op_count: got %0d want %0d", nm, op_q.size(), 5 * exp_done.size());
        end
        for (int i = 0; i < op_q.size(); i++) begin
            n_cmp++;
            if (op_q[i] !== 3'((i % 5) + 1)) begin
                n_fail++;
                $display("FAIL %s op_code[%0d]: got %0d want %0d", nm, i, op_q[i], (i % 5) + 1);
            end
        end
        n_cmp++;
        if (overrun_cnt - ovr0 !== 16'(n_ovr)) begin
            n_fail++;
            $display("FAIL %s overrun: got %0d want %0d", nm, overrun_cnt - ovr0, n_ovr);
        end
    endtask

    task automatic test_timeout();
        int s, k, n;
        @(negedge clk);
        clear_q();
        resp_en = 1'b0; lat = 1;
        bus.S_AXIS_IN_tdata = $urandom; bus.S_AXIS_IN_tvalid = 1'b1;
        period = 16'd20;
        enable = 1'b1;
        k = 0;
        while (opc_q.size() == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        n_cmp++;
        if (opc_q.size() == 0) begin
            n_fail++;
            $display("FAIL timeout_start: got no op_start want op_start within 100 cycles");
            return;
        end
        s = opc_q[0];
        while (cyc < s + 255) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got busy %b err %b want busy 1 err 0", busy, timeout_err);
        end
        while (cyc < s + 257) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_abort: got busy %b err %b done %0d want busy 0 err 1 done 0", busy, timeout_err, done_q.size());
        end
        resp_en = 1'b1;
        n = op_q.size();
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        k = 0;
        while (op_q.size() <= n && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (op_q.size() != n + 1 || (op_q.size() > n && op_q[n] !== 3'd0)) begin
            n_fail++;
            $display("FAIL init_op: got %0d new ops want exactly one op 0", op_q.size() - n);
        end
        n_cmp++;
        if (timeout_err !== 1'b0 || busy !== 1'b0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL init_clear: got err %b busy %b done %0d want 0 0 0", timeout_err, busy, done_q.size());
        end
    endtask

    task automatic test_init_tick();
        int c, p;
        logic [15:0] ovr0;
        p = $urandom_range(6, 12);
        @(negedge clk);
        clear_q();
        lat = 1; resp_en = 1'b1;
        bus.S_AXIS_IN_tdata = $urandom; bus.S_AXIS_IN_tvalid = 1'b1;
        period = 16'(p);
        ovr0 = overrun_cnt;
        c = cyc;
        enable = 1'b1;
        while (cyc < c + p - 2) @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        while (cyc < c + 2 * p) @(negedge clk);
        enable = 1'b0;
        repeat (25) @(negedge clk);
        n_cmp++;
        if (overrun_cnt - ovr0 !== 16'd1) begin
            n_fail++;
            $display("FAIL init_tick_overrun: got %0d want 1", overrun_cnt - ovr0);
        end
        n_cmp++;
        if (op_q.size() != 6 || op_q[0] !== 3'd0 || opc_q[0] != c + p) begin
            n_fail++;
            $display("FAIL init_tick_ops: got %0d ops first code %0d at %0d want 6 ops first 0 at %0d",
                     op_q.size(), op_q.size() > 0 ? op_q[0] : 3'd7, opc_q.size() > 0 ? opc_q[0] : -1, c + p);
        end
        n_cmp++;
        if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != c + 2 * p - 1 + 12)) begin
            n_fail++;
            $display("FAIL init_tick_done: got %0d dones first %0d want 1 at %0d",
                     done_q.size(), done_q.size() > 0 ? done_q[0] : -1, c + 2 * p + 11);
        end
    endtask

    task automatic test_stall();
        int c, t;
        logic [31:0] d;
        logic [15:0] ovr0;
        d = $urandom;
        @(negedge clk);
        clear_q();
        lat = 1; resp_en = 1'b1;
        bus.S_AXIS_IN_tvalid = 1'b0; bus.S_AXIS_IN_tdata = $urandom;
        period = 16'd20;
        ovr0 = overrun_cnt;
        c = cyc;
        enable = 1'b1;
        t = c + 19;
        while (cyc < t + 50) @(negedge clk);
        n_cmp++;
        if (bus.S_AXIS_IN_tready !== 1'b1 || busy !== 1'b1 || overrun_cnt - ovr0 !== 16'd2) begin
            n_fail++;
            $display("FAIL stall_hold: got tready %b busy %b ovr %0d want 1 1 2", bus.S_AXIS_IN_tready, busy, overrun_cnt - ovr0);
        end
        enable = 1'b0;
        bus.S_AXIS_IN_tdata = d;
        bus.S_AXIS_IN_tvalid = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != t + 61)) begin
            n_fail++;
            $display("FAIL stall_done: got %0d dones first %0d want 1 at %0d", done_q.size(), done_q.size() > 0 ? done_q[0] : -1, t + 61);
        end
        n_cmp++;
        if (sample_out !== d[13:0] || load_q.size() != 1 || overrun_cnt - ovr0 !== 16'd2) begin
            n_fail++;
            $display("FAIL stall_sample: got %h loads %0d ovr %0d want %h 1 2", sample_out, load_q.size(), overrun_cnt - ovr0, d[13:0]);
        end
    endtask

    task automatic test_async_reset();
        int k, c;
        @(negedge clk);
        clear_q();
        lat = 2; resp_en = 1'b1;
        bus.S_AXIS_IN_tvalid = 1'b1; bus.S_AXIS_IN_tdata = $urandom | 32'h1;
        period = 16'd10;
        enable = 1'b1;
        k = 0;
        while (!(bus.op_start === 1'b1 && bus.op_code === 3'd3) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL arst_reach: got no op 3 want op 3 within 200 cycles");
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.op_start, bus.op_code, bus.S_AXIS_IN_tready, busy, sample_out, sample_load,
             update_done, timeout_err, overrun_cnt} !== 39'd0) begin
            n_fail++;
            $display("FAIL arst_outputs: got %h want 0", {bus.op_start, bus.op_code, bus.S_AXIS_IN_tready, busy,
                     sample_out, sample_load, update_done, timeout_err, overrun_cnt});
        end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_q();
        c = cyc;
        enable = 1'b1;
        k = 0;
        while (op_q.size() == 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (op_q.size() == 0 || op_q[0] !== 3'd1 || opc_q[0] != c + 11) begin
            n_fail++;
            $display("FAIL arst_restart: got %0d ops first %0d at %0d want op 1 at %0d",
                     op_q.size(), op_q.size() > 0 ? op_q[0] : 3'd7, opc_q.size() > 0 ? opc_q[0] : -1, c + 11);
        end
        n_cmp++;
        if (done_q.size() != 1) begin
            n_fail++;
            $display("FAIL arst_done: got %0d want 1", done_q.size());
        end
    endtask

    task automatic test_disable_mid(input bit use_period);
        int c, k;
        logic [15:0] ovr0;
        @(negedge clk);
        clear_q();
        lat = 3; resp_en = 1'b1;
        bus.S_AXIS_IN_tvalid = 1'b1; bus.S_AXIS_IN_tdata = $urandom;
        period = 16'd12;
        ovr0 = overrun_cnt;
        c = cyc;
        enable = 1'b1;
        k = 0;
        while (op_q.size() == 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (use_period) period = 16'd0;
        else enable = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != c + 11 + 7 + 15)) begin
            n_fail++;
            $display("FAIL stop%0d_done: got %0d dones first %0d want 1 at %0d",
                     use_period, done_q.size(), done_q.size() > 0 ? done_q[0] : -1, c + 33);
        end
        n_cmp++;
        if (op_q.size() != 5 || overrun_cnt - ovr0 !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop%0d_quiet: got ops %0d ovr %0d busy %b want 5 0 0",
                     use_period, op_q.size(), overrun_cnt - ovr0, busy);
        end
        enable = 1'b0;
        period = 16'd12;
    endtask

    initial begin
        bus.S_AXIS_IN_tdata = '0;
        bus.S_AXIS_IN_tvalid = 1'b0;
        test_reset();
        test_periodic("t1_p20", 20, 1, 100);
        test_periodic("t2_p8", 8, 1, 80);
        for (int r = 0; r < 4; r++)
            test_periodic($sformatf("rand%0d", r), $urandom_range(3, 40), $urandom_range(1, 4), $urandom_range(60, 150));
        test_timeout();
        test_init_tick();
        test_stall();
        test_async_reset();
        test_disable_mid(1'b0);
        test_disable_mid(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
